// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I core front end.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] CPU_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage and memory.
interface if_fetch_stage_if;
  import cpu_pkg::*;

  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [XLEN-1:0] im_rdata;

  modport master (
    output im_req, im_addr,
    input  im_gnt, im_rvalid, im_rdata
  );

  modport slave (
    input  im_req, im_addr,
    output im_gnt, im_rvalid, im_rdata
  );

endinterface

// File: rtl/if_fetch_stage_pipe_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_pipe_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = CPU_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_add4,
  output logic [XLEN-1:0] if_id_inst,
  output logic            if_id_valid
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_add4_q, pc_add4_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d      = pc_q;
    pc_add4_d = pc_add4_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    if (flush) begin
      valid_d = 1'b0;
      inst_d  = NOP;
    end else if (!stall) begin
      if (load) begin
        pc_d      = load_pc;
        pc_add4_d = load_pc + 32'd4;
        inst_d    = load_inst;
        valid_d   = 1'b1;
      end else begin
        valid_d = 1'b0;
        inst_d  = NOP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      pc_add4_q <= '0;
      inst_q    <= NOP;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_add4_q <= pc_add4_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
    end
  end

  assign if_id_pc      = pc_q;
  assign if_id_pc_add4 = pc_add4_q;
  assign if_id_inst    = inst_q;
  assign if_id_valid   = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, runs the instruction-memory handshake and feeds IF/ID,
// dropping responses made stale by a redirect.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = CPU_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = CPU_NOP_INST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  if_fetch_stage_if.master im,
  output logic [XLEN-1:0]  IF_ID_PC,
  output logic [XLEN-1:0]  IF_ID_PCAdd4,
  output logic [XLEN-1:0]  IF_ID_inst,
  output logic             IF_ID_valid
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_inst_q, hold_inst_d;

  logic            load;
  logic [XLEN-1:0] load_pc;
  logic [XLEN-1:0] load_inst;
  logic [XLEN-1:0] target_pc;

  assign target_pc  = align_pc(redirect_pc);
  assign im.im_req  = (state_q == REQ);
  assign im.im_addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    load        = 1'b0;
    load_pc     = pc_q;
    load_inst   = im.im_rdata;

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (redirect) pc_d = target_pc;
        // A redirect in the grant cycle still leaves one response to swallow.
        if (im.im_gnt) begin
          state_d = WAIT;
          if (redirect) kill_d = 1'b1;
        end
      end

      WAIT: begin
        if (im.im_rvalid) begin
          state_d = REQ;
          if (kill_q) begin
            kill_d = 1'b0;
            if (redirect) pc_d = target_pc;
          end else if (redirect) begin
            pc_d = target_pc;
          end else if (!id_stall) begin
            load = 1'b1;
            pc_d = pc_q + 32'd4;
          end else begin
            hold_pc_d   = pc_q;
            hold_inst_d = im.im_rdata;
            pc_d        = pc_q + 32'd4;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = target_pc;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target_pc;
          state_d = REQ;
        end else if (!id_stall) begin
          load      = 1'b1;
          load_pc   = hold_pc_q;
          load_inst = hold_inst_q;
          state_d   = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      hold_pc_q   <= '0;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  if_id_pipe_reg #(.NOP(NOP_INST)) u_if_id (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect),
    .stall        (id_stall),
    .load         (load),
    .load_pc      (load_pc),
    .load_inst    (load_inst),
    .if_id_pc     (IF_ID_PC),
    .if_id_pc_add4(IF_ID_PCAdd4),
    .if_id_inst   (IF_ID_inst),
    .if_id_valid  (IF_ID_valid)
  );

  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (rst)
    im.im_rvalid |-> (state_q == WAIT));

  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (im.im_req && !im.im_gnt && !redirect) |=> (im.im_req && $stable(im.im_addr)));

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
    pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a simple latency-programmable memory responder.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_add4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  if_fetch_stage_if im_bus();

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im          (im_bus),
    .IF_ID_PC    (if_id_pc),
    .IF_ID_PCAdd4(if_id_pc_add4),
    .IF_ID_inst  (if_id_inst),
    .IF_ID_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          lat    = 1;
  logic        busy   = 1'b0;
  int          age    = 0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (if_id_valid) break;
      @(negedge clk);
    end
    chk(tag, {31'b0, if_id_valid}, 32'd1);
  endtask

  // Responder: samples accepts 2ns after each falling edge, answers lat cycles later.
  initial begin
    im_bus.im_rvalid = 1'b0;
    im_bus.im_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      im_bus.im_rvalid = 1'b0;
      if (busy) begin
        age++;
        if (age >= lat) begin
          im_bus.im_rvalid = 1'b1;
          im_bus.im_rdata  = mem_word(pend_addr);
          busy = 1'b0;
        end
      end
      if (im_bus.im_req && im_bus.im_gnt) begin
        busy      = 1'b1;
        age       = 0;
        pend_addr = im_bus.im_addr;
      end
    end
  end

  initial begin
    im_bus.im_gnt = 1'b1;

    // reset values
    tick();
    chk("rst_req",   {31'b0, im_bus.im_req}, 32'd0);
    chk("rst_pc",    if_id_pc,      32'h0);
    chk("rst_pc4",   if_id_pc_add4, 32'h0);
    chk("rst_inst",  if_id_inst,    32'h13);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    #1 rst = 1'b0;

    // sequential fetch, 1 instr / 2 cycles
    tick();
    chk("t1_req0",  {31'b0, im_bus.im_req}, 32'd1);
    chk("t1_addr0", im_bus.im_addr, 32'h0);
    tick();
    chk("t1_wait_req", {31'b0, im_bus.im_req}, 32'd0);
    tick();
    chk("t1_pc0",    if_id_pc,      32'h0);
    chk("t1_pc4_0",  if_id_pc_add4, 32'h4);
    chk("t1_inst0",  if_id_inst,    mem_word(32'h0));
    chk("t1_valid0", {31'b0, if_id_valid}, 32'd1);
    chk("t1_addr4",  im_bus.im_addr, 32'h4);
    tick();
    chk("t1_bubble", {31'b0, if_id_valid}, 32'd0);
    tick();
    chk("t1_pc1",   if_id_pc, 32'h4);
    chk("t1_addr8", im_bus.im_addr, 32'h8);
    tick();
    tick();
    chk("t1_pc2",    if_id_pc, 32'h8);
    chk("t1_valid2", {31'b0, if_id_valid}, 32'd1);
    chk("t1_addr12", im_bus.im_addr, 32'hC);

    // ID stall with next word buffered
    id_stall = 1'b1;
    tick();
    tick();
    chk("t2_hold_req", {31'b0, im_bus.im_req}, 32'd0);
    chk("t2_hold_pc",  if_id_pc, 32'h8);
    chk("t2_hold_vld", {31'b0, if_id_valid}, 32'd1);
    tick();
    chk("t2_hold_req2", {31'b0, im_bus.im_req}, 32'd0);
    chk("t2_hold_pc2",  if_id_pc, 32'h8);
    id_stall = 1'b0;
    tick();
    chk("t2_rel_pc",   if_id_pc,      32'hC);
    chk("t2_rel_pc4",  if_id_pc_add4, 32'h10);
    chk("t2_rel_inst", if_id_inst,    mem_word(32'hC));
    chk("t2_rel_addr", im_bus.im_addr, 32'h10);

    // redirect while the response arrives
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t3_inst",  if_id_inst, 32'h13);
    chk("t3_pchold", if_id_pc, 32'hC);
    chk("t3_addr",  im_bus.im_addr, 32'h100);
    #1 lat = 2;

    // redirect in WAIT before the response: response must be killed
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("t3k_wait_req", {31'b0, im_bus.im_req}, 32'd0);
    tick();
    chk("t3k_req",  {31'b0, im_bus.im_req}, 32'd1);
    chk("t3k_addr", im_bus.im_addr, 32'h200);
    chk("t3k_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    tick();
    tick();
    chk("t3k_pc",   if_id_pc,      32'h200);
    chk("t3k_pc4",  if_id_pc_add4, 32'h204);
    chk("t3k_inst", if_id_inst,    mem_word(32'h200));
    chk("t3k_addr2", im_bus.im_addr, 32'h204);

    // redirect and stall together: flush wins, low PC bits dropped
    id_stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick();
    chk("t4_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t4_inst",  if_id_inst, 32'h13);
    chk("t4_pc",    if_id_pc,   32'h200);
    id_stall = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    chk("t4_req",  {31'b0, im_bus.im_req}, 32'd1);
    chk("t4_addr", im_bus.im_addr, 32'h100);

    // PC wrap at top of address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_valid("t5_valid");
    chk("t5_pc",   if_id_pc,      32'hFFFF_FFFC);
    chk("t5_pc4",  if_id_pc_add4, 32'h0);
    chk("t5_inst", if_id_inst,    mem_word(32'hFFFF_FFFC));
    chk("t5_addr", im_bus.im_addr, 32'h0);

    // async reset mid-WAIT, late response lands while in reset
    #1 lat = 3;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk("t6_req",   {31'b0, im_bus.im_req}, 32'd0);
    chk("t6_pc",    if_id_pc,      32'h0);
    chk("t6_pc4",   if_id_pc_add4, 32'h0);
    chk("t6_inst",  if_id_inst,    32'h13);
    chk("t6_valid", {31'b0, if_id_valid}, 32'd0);
    tick();
    tick();
    chk("t6_late_valid", {31'b0, if_id_valid}, 32'd0);
    chk("t6_late_inst",  if_id_inst, 32'h13);
    #3;
    lat = 1;
    im_bus.im_gnt = 1'b0;
    rst = 1'b0;

    // request held while grant is withheld
    tick();
    chk("t6_req_hold",  {31'b0, im_bus.im_req}, 32'd1);
    chk("t6_addr_hold", im_bus.im_addr, 32'h0);
    tick();
    chk("t6_req_hold2",  {31'b0, im_bus.im_req}, 32'd1);
    chk("t6_addr_hold2", im_bus.im_addr, 32'h0);
    im_bus.im_gnt = 1'b1;
    tick();
    tick();
    chk("t6_pc_after",    if_id_pc,   32'h0);
    chk("t6_inst_after",  if_id_inst, mem_word(32'h0));
    chk("t6_valid_after", {31'b0, if_id_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
